// File: rtl/jtframe_mist_pkg.sv
// Shared constants, FSM encodings and framing helpers for the MiST data-port downloader.
package jtframe_mist_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

    localparam logic [7:0] TX_START_ARG = 8'hFF;
    localparam logic [7:0] TX_END_ARG   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IDX,
        ST_START,
        ST_DATA,
        ST_END,
        ST_GAP,
        ST_FIN
    } dl_state_e;

    // Sub-phase inside any frame state: SS2-low setup, byte shifting, SCK-low tail.
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_BYTES,
        PH_TAIL
    } frame_phase_e;

    function automatic logic [7:0] frame_cmd(input dl_state_e st);
        case (st)
            ST_IDX:  return UIO_FILE_INDEX;
            ST_DATA: return UIO_FILE_TX_DAT;
            default: return UIO_FILE_TX;
        endcase
    endfunction

    function automatic dl_state_e frame_after(input dl_state_e st, input logic len_zero);
        case (st)
            ST_IDX:   return ST_START;
            ST_START: return len_zero ? ST_END : ST_DATA;
            ST_DATA:  return ST_END;
            default:  return ST_FIN;
        endcase
    endfunction

endpackage

// File: rtl/jtframe_spi_byte_tx.sv
// SPI mode-0 byte shifter, MSB first, with SCK divider and load/ready handshake.
// ready_o also rises on the final cycle of bit 0 so a queued byte follows with no extra gap.
module jtframe_spi_byte_tx #(
    parameter int SCK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       sck_o,
    output logic       di_o,
    output logic       last_bit_o
);

    localparam logic [7:0] DIV_LAST = 8'(SCK_DIV - 1);

    logic       busy_q, busy_d;
    logic       sck_q, sck_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] div_q, div_d;
    logic [7:0] sh_q, sh_d;
    logic       final_cycle;

    assign final_cycle = busy_q && (bit_q == 3'd0) && sck_q && (div_q == DIV_LAST);

    // NOTE: every next-state signal gets its default first so no path infers a latch.
    always_comb begin
        busy_d = busy_q;
        sck_d  = sck_q;
        bit_d  = bit_q;
        div_d  = div_q;
        sh_d   = sh_q;
        if ((!busy_q || final_cycle) && load_i) begin
            busy_d = 1'b1;
            sck_d  = 1'b0;
            bit_d  = 3'd7;
            div_d  = 8'd0;
            sh_d   = data_i;
        end else if (busy_q) begin
            if (div_q == DIV_LAST) begin
                div_d = 8'd0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    // DI only moves on the falling edge, keeping it stable while SCK is high.
                    sck_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        busy_d = 1'b0;
                    end else begin
                        bit_d = bit_q - 3'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            bit_q  <= 3'd0;
            div_q  <= 8'd0;
            sh_q   <= 8'd0;
        end else begin
            busy_q <= busy_d;
            sck_q  <= sck_d;
            bit_q  <= bit_d;
            div_q  <= div_d;
            sh_q   <= sh_d;
        end
    end

    assign ready_o    = !busy_q || final_cycle;
    assign sck_o      = sck_q;
    assign di_o       = sh_q[7];
    assign last_bit_o = busy_q && (bit_q == 3'd0);

endmodule

// File: rtl/jtframe_mist_dlsend.sv
// Streams a file into a MiST core's SPI data port: [INDEX,] START, DATA, END frames.
// Define JTFRAME_DLSEND_INDEX_EN to emit the INDEX frame ahead of START.
module jtframe_mist_dlsend
    import jtframe_mist_pkg::*;
#(
    parameter int SCK_DIV = 4,
    parameter int SS_GAP  = 8
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic [24:0] len,
    output logic        src_req,
    output logic [24:0] src_addr,
    input  logic        src_ack,
    input  logic [7:0]  src_data,
    output logic        SPI_SCK,
    output logic        SPI_SS2,
    output logic        SPI_DI,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] SCK_LAST = 16'(SCK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(SS_GAP - 1);

    dl_state_e    state_q, state_d, next_q, next_d;
    frame_phase_e phase_q, phase_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [25:0]  byte_idx_q, byte_idx_d;
    logic [24:0]  len_q, len_d;
    logic         src_req_q, src_req_d;
    logic [24:0]  src_addr_q, src_addr_d;
    logic [7:0]   buf_q, buf_d;
    logic         buf_vld_q, buf_vld_d;
    logic         ss2_q, ss2_d;

    logic         tx_load, tx_ready, tx_last;
    logic [7:0]   tx_data;
    logic [25:0]  frame_total;
    logic [7:0]   idx_byte;

`ifdef JTFRAME_DLSEND_INDEX_EN
    localparam dl_state_e FIRST_FRAME = ST_IDX;
    logic [7:0] index_q;

    always_ff @(posedge clk_sys) begin
        if (rst)                                 index_q <= 8'd0;
        else if (state_q == ST_IDLE && start)    index_q <= index;
    end

    assign idx_byte = index_q;
`else
    localparam dl_state_e FIRST_FRAME = ST_START;
    logic unused_index;

    assign unused_index = ^index;
    assign idx_byte     = 8'h00;
`endif

    assign frame_total = (state_q == ST_DATA) ? ({1'b0, len_q} + 26'd1) : 26'd2;

    always_comb begin
        state_d    = state_q;
        next_d     = next_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        len_d      = len_q;
        src_addr_d = src_addr_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        tx_load    = 1'b0;
        tx_data    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = FIRST_FRAME;
                    phase_d    = PH_SETUP;
                    cnt_d      = 16'd0;
                    byte_idx_d = 26'd0;
                    len_d      = len;
                    src_addr_d = 25'd0;
                    buf_vld_d  = 1'b0;
                end
            end
            ST_IDX, ST_START, ST_DATA, ST_END: begin
                case (phase_q)
                    PH_SETUP: begin
                        if (cnt_q == GAP_LAST) begin
                            phase_d = PH_BYTES;
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    PH_BYTES: begin
                        if (byte_idx_q == frame_total) begin
                            // Wait for the final bit to leave before starting the tail.
                            if (tx_ready && !tx_last) begin
                                phase_d = PH_TAIL;
                                cnt_d   = 16'd0;
                            end
                        end else if (tx_ready) begin
                            if (byte_idx_q == 26'd0) begin
                                tx_load    = 1'b1;
                                tx_data    = frame_cmd(state_q);
                                byte_idx_d = byte_idx_q + 26'd1;
                            end else if (state_q != ST_DATA) begin
                                tx_load    = 1'b1;
                                tx_data    = (state_q == ST_IDX)   ? idx_byte :
                                             (state_q == ST_START) ? TX_START_ARG : TX_END_ARG;
                                byte_idx_d = byte_idx_q + 26'd1;
                            end else if (buf_vld_q) begin
                                tx_load    = 1'b1;
                                tx_data    = buf_q;
                                buf_vld_d  = 1'b0;
                                byte_idx_d = byte_idx_q + 26'd1;
                            end
                        end
                    end
                    default: begin
                        if (cnt_q == SCK_LAST) begin
                            state_d = ST_GAP;
                            next_d  = frame_after(state_q, len_q == 25'd0);
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                endcase
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d    = next_q;
                    phase_d    = PH_SETUP;
                    cnt_d      = 16'd0;
                    byte_idx_d = 26'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // One-byte prefetch buffer: the next byte is fetched while the current one shifts.
        src_req_d = (state_q == ST_DATA) && !buf_vld_q && (src_addr_q < len_q) &&
                    !(src_req_q && src_ack);
        if (src_req_q && src_ack) begin
            buf_d      = src_data;
            buf_vld_d  = 1'b1;
            src_addr_d = src_addr_q + 25'd1;
        end

        ss2_d = !(state_d inside {ST_IDX, ST_START, ST_DATA, ST_END});
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            next_q     <= ST_IDLE;
            phase_q    <= PH_SETUP;
            cnt_q      <= 16'd0;
            byte_idx_q <= 26'd0;
            len_q      <= 25'd0;
            src_req_q  <= 1'b0;
            src_addr_q <= 25'd0;
            buf_q      <= 8'd0;
            buf_vld_q  <= 1'b0;
            ss2_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            next_q     <= next_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            len_q      <= len_d;
            src_req_q  <= src_req_d;
            src_addr_q <= src_addr_d;
            buf_q      <= buf_d;
            buf_vld_q  <= buf_vld_d;
            ss2_q      <= ss2_d;
        end
    end

    jtframe_spi_byte_tx #(
        .SCK_DIV    (SCK_DIV)
    ) u_tx (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .load_i     (tx_load),
        .data_i     (tx_data),
        .ready_o    (tx_ready),
        .sck_o      (SPI_SCK),
        .di_o       (SPI_DI),
        .last_bit_o (tx_last)
    );

    assign src_req  = src_req_q;
    assign src_addr = src_addr_q;
    assign SPI_SS2  = ss2_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIN);

endmodule

// File: tb/tb_jtframe_mist_dlsend.sv
// Self-checking bench: decodes the SPI lines into frames and scores them against a frame model.
module tb_jtframe_mist_dlsend;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  index;
    logic [24:0] len;
    logic        src_req;
    logic [24:0] src_addr;
    logic        src_ack;
    logic [7:0]  src_data;
    logic        SPI_SCK, SPI_SS2, SPI_DI;
    logic        busy, done;

    always #5 clk_sys = ~clk_sys;

    jtframe_mist_dlsend #(.SCK_DIV(4), .SS_GAP(8)) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .start    (start),
        .index    (index),
        .len      (len),
        .src_req  (src_req),
        .src_addr (src_addr),
        .src_ack  (src_ack),
        .src_data (src_data),
        .SPI_SCK  (SPI_SCK),
        .SPI_SS2  (SPI_SS2),
        .SPI_DI   (SPI_DI),
        .busy     (busy),
        .done     (done)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          n;
        logic [63:0] bytes;
    } frame_t;

    frame_t exp_q[$];

    typedef struct {
        logic [7:0]  idx;
        logic [24:0] len;
        logic [55:0] data;
        int          ack;
        int          stall_addr;
        int          stall_cyc;
        bit          restart;
    } vec_t;

    // ---------------- SPI decoder / scoreboard consumer ----------------
    logic        prev_sck = 1'b0, prev_ss2 = 1'b1, prev_di = 1'b0;
    logic [7:0]  sh = 8'd0;
    logic [7:0]  fcmd = 8'd0;
    logic [63:0] fbytes = 64'd0;
    int          bits = 0, nbytes = 0, done_cnt = 0;
    bit          in_frame = 1'b0;

    task automatic frame_end();
        frame_t e;
        if (exp_q.size() == 0) begin
            check("frame_extra_bytes", 64'(nbytes), 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("frame_len", 64'(nbytes), 64'(e.n));
            check("frame_bytes", fbytes, e.bytes);
            check("frame_tail_bits", 64'(bits), 64'd0);
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst) begin
            in_frame = 1'b0;
            bits     = 0;
            nbytes   = 0;
            prev_sck = 1'b0;
            prev_ss2 = 1'b1;
        end else begin
            if (done) done_cnt++;
            if (prev_ss2 && !SPI_SS2) begin
                in_frame = 1'b1;
                bits     = 0;
                nbytes   = 0;
                fbytes   = 64'd0;
            end
            if (SPI_SCK && prev_sck) check("di_stable", 64'(SPI_DI), 64'(prev_di));
            if (SPI_SS2) check("sck_idle_ss2_high", 64'(SPI_SCK), 64'd0);
            if (in_frame && !prev_sck && SPI_SCK) begin
                sh = {sh[6:0], SPI_DI};
                bits++;
                if (bits == 8) begin
                    fbytes = {fbytes[55:0], sh};
                    if (nbytes == 0) fcmd = sh;
                    nbytes++;
                    bits = 0;
                end
            end
            if (in_frame && !prev_ss2 && SPI_SS2) begin
                in_frame = 1'b0;
                frame_end();
            end
            prev_sck = SPI_SCK;
            prev_ss2 = SPI_SS2;
            prev_di  = SPI_DI;
        end
    end

    // ---------------- byte source model ----------------
    logic [7:0] mem [16];
    int         ack_dly = 1, stall_addr = -1, stall_cyc = 0;
    int         exp_addr = 0, req_age = 0;
    bit         req_seen = 1'b0;

    initial begin
        src_ack  = 1'b0;
        src_data = 8'd0;
        forever begin
            @(negedge clk_sys);
            src_ack = 1'b0;
            if (!rst && src_req) begin
                req_seen = 1'b1;
                req_age++;
                if (req_age == 150) begin
                    check("stall_ss2_low", 64'(SPI_SS2), 64'd0);
                    check("stall_sck_low", 64'(SPI_SCK), 64'd0);
                end
                if (req_age >= ((int'(src_addr) == stall_addr) ? stall_cyc : ack_dly)) begin
                    check("src_addr", 64'(src_addr), 64'(exp_addr));
                    src_data = mem[src_addr[3:0]];
                    src_ack  = 1'b1;
                    exp_addr++;
                    req_age = 0;
                end
            end else begin
                req_age = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input logic [7:0] idx, input logic [24:0] l);
        @(negedge clk_sys);
        index = idx;
        len   = l;
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic push_frame(input int n, input logic [63:0] b);
        frame_t f;
        f.n     = n;
        f.bytes = b;
        exp_q.push_back(f);
    endtask

    task automatic push_expected(input logic [7:0] idx, input logic [24:0] l);
        logic [63:0] b;
`ifdef JTFRAME_DLSEND_INDEX_EN
        push_frame(2, {48'd0, 8'h55, idx});
`endif
        push_frame(2, 64'h53FF);
        if (l != 25'd0) begin
            b = 64'h54;
            for (int i = 0; i < int'(l); i++) b = {b[55:0], mem[i]};
            push_frame(int'(l) + 1, b);
        end
        push_frame(2, 64'h5300);
    endtask

    task automatic setup_vector(input vec_t v);
        for (int i = 0; i < 7; i++) mem[i] = v.data[55 - 8*i -: 8];
        ack_dly    = v.ack;
        stall_addr = v.stall_addr;
        stall_cyc  = v.stall_cyc;
        exp_addr   = 0;
        req_seen   = 1'b0;
        done_cnt   = 0;
        exp_q.delete();
        push_expected(v.idx, v.len);
    endtask

    task automatic run_vector(input vec_t v);
        bit ok;
        setup_vector(v);
        pulse_start(v.idx, v.len);
        check("busy_after_start", 64'(busy), 64'd1);
        if (v.restart) begin
            repeat (60) @(negedge clk_sys);
            pulse_start(8'h07, 25'd9);
        end
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_sys);
            if (done_cnt > 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(ok), 64'd1);
        repeat (20) @(negedge clk_sys);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("frames_left", 64'(exp_q.size()), 64'd0);
        check("src_addr_end", 64'(src_addr), 64'(v.len));
        check("src_req_seen", 64'(req_seen), 64'(v.len != 25'd0));
        check("busy_end", 64'(busy), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        bit found;

        vecs[0] = '{8'h02, 25'd4, 56'hA55A00FF000000, 1, -1, 0,   1'b0};
        vecs[1] = '{8'h02, 25'd0, 56'h0,              1, -1, 0,   1'b0};
        vecs[2] = '{8'h11, 25'd5, 56'h01807EC33C0000, 1,  2, 200, 1'b0};
        vecs[3] = '{8'h02, 25'd3, 56'h12345600000000, 1, -1, 0,   1'b1};
        vecs[4] = '{8'h09, 25'd1, 56'h99000000000000, 3, -1, 0,   1'b0};
        vecs[5] = '{8'hFF, 25'd7, 56'hF00F55AA0180C3, 5, -1, 0,   1'b0};

        rst   = 1'b1;
        start = 1'b0;
        index = 8'd0;
        len   = 25'd0;
        repeat (3) @(negedge clk_sys);
        check("rst_ss2", 64'(SPI_SS2), 64'd1);
        check("rst_sck", 64'(SPI_SCK), 64'd0);
        check("rst_di", 64'(SPI_DI), 64'd0);
        check("rst_src_req", 64'(src_req), 64'd0);
        check("rst_src_addr", 64'(src_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_sys);

        for (int k = 0; k < 6; k++) run_vector(vecs[k]);

        // Abort at bit 3 of the DATA frame's second byte, then restart cleanly.
        setup_vector(vecs[0]);
        pulse_start(vecs[0].idx, vecs[0].len);
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_sys);
            if (in_frame && fcmd == 8'h54 && nbytes == 2 && bits == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_point_found", 64'(found), 64'd1);
        check("frames_before_abort", 64'(exp_q.size()), 64'd2);
        rst = 1'b1;
        @(posedge clk_sys);
        #1;
        check("abort_ss2", 64'(SPI_SS2), 64'd1);
        check("abort_sck", 64'(SPI_SCK), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_src_req", 64'(src_req), 64'd0);
        @(negedge clk_sys);
        rst = 1'b0;
        repeat (2) @(negedge clk_sys);
        run_vector(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
